// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt pending/mask/service stage.
package irq_pkg;

  localparam int NSRC  = 8;
  localparam int IDX_W = 3;

  localparam logic [NSRC-1:0] EDGE_MODE_DEF = 8'hFF;
  localparam logic [NSRC-1:0] MASK_RST_DEF  = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    RETIRE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_pend_ctrl_oh2idx.sv
// One-hot to binary index encoder; the highest set bit wins on a malformed input.
module oh2idx
  import irq_pkg::*;
(
  input  logic [NSRC-1:0]  oh,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// Interrupt pending/mask/service stage feeding an external one-hot priority stage.
module irq_pend_ctrl
  import irq_pkg::*;
#(
  parameter logic [NSRC-1:0] EDGE_MODE = EDGE_MODE_DEF,
  parameter logic [NSRC-1:0] MASK_RST  = MASK_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  src,
  input  logic             mask_wr,
  input  logic [NSRC-1:0]  mask_in,
  input  logic [NSRC-1:0]  sel,
  input  logic             ack,
  input  logic             ovf_clr,
  output logic [NSRC-1:0]  pend,
  output logic             irq,
  output logic [IDX_W-1:0] irq_idx,
  output logic [NSRC-1:0]  ovf
);

  logic [NSRC-1:0]  src_q;
  logic [NSRC-1:0]  pend_r;
  logic [NSRC-1:0]  mask;
  logic [NSRC-1:0]  svc;
  logic [NSRC-1:0]  set_v;
  logic [NSRC-1:0]  clr_v;
  logic [NSRC-1:0]  ovf_set;
  logic [IDX_W-1:0] sel_idx;
  state_t           state;
  state_t           state_nxt;
  logic             cap;

  // Level-mode bits ignore the previous sample, so they set whenever high.
  assign set_v   = src & ~(src_q & EDGE_MODE);
  assign clr_v   = (state == RETIRE) ? svc : '0;
  assign ovf_set = set_v & pend_r & ~clr_v & EDGE_MODE;
  assign pend    = pend_r & mask;

  oh2idx u_oh2idx (
    .oh  (sel),
    .idx (sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      pend_r <= '0;
      mask   <= MASK_RST;
      ovf    <= '0;
    end else begin
      src_q  <= src;
      pend_r <= set_v | (pend_r & ~clr_v);
      if (mask_wr) mask <= mask_in;
      ovf    <= (ovf & ~{NSRC{ovf_clr}}) | ovf_set;
    end
  end

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (sel != '0) begin
          cap       = 1'b1;
          state_nxt = SERVE;
        end
      end
      SERVE:   if (ack) state_nxt = RETIRE;
      RETIRE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // svc and irq_idx are frozen for the whole service, whatever sel does meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      svc     <= '0;
      irq     <= 1'b0;
      irq_idx <= '0;
    end else begin
      irq <= (state_nxt == SERVE);
      if (cap) begin
        svc     <= sel;
        irq_idx <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl with a behavioural model and per-cycle comparison.
module tb_irq_pend_ctrl;

  localparam logic [7:0] EM = 8'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] src = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_in = '0;
  logic [7:0] sel;
  logic       ack = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] pend;
  logic       irq;
  logic [2:0] irq_idx;
  logic [7:0] ovf;

  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = '0;
  logic [7:0] sel_prio;

  int checks = 0;
  int errors = 0;

  logic       chk_on = 1'b0;
  logic       pin_on = 1'b0;
  logic [3:0] pin_msk = '0;
  logic [7:0] pin_pend = '0;
  logic       pin_irq = 1'b0;
  logic [2:0] pin_idx = '0;
  logic [7:0] pin_ovf = '0;
  string      pin_name = "";

  // Model state: pending bits, previous source sample, mask, service phase.
  logic [7:0] m_pend_r, m_srcq, m_mask, m_svc, m_ovf;
  logic [7:0] m_set, m_clr, m_sel;
  int         m_ph;
  logic [2:0] m_idx;

  always #5 clk = ~clk;

  function automatic logic [7:0] prio(input logic [7:0] v);
    logic [7:0] r = '0;
    for (int i = 7; i >= 0; i--) if (v[i] && r == 8'h00) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [2:0] hi(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Priority stage stand-in, with an override for protocol-error stimulus.
  always_comb begin
    sel_prio = prio(pend);
    sel      = ovr_en ? ovr_val : sel_prio;
  end

  irq_pend_ctrl #(.EDGE_MODE(EM), .MASK_RST(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .src     (src),
    .mask_wr (mask_wr),
    .mask_in (mask_in),
    .sel     (sel),
    .ack     (ack),
    .ovf_clr (ovf_clr),
    .pend    (pend),
    .irq     (irq),
    .irq_idx (irq_idx),
    .ovf     (ovf)
  );

  always @(posedge clk) begin
    if (rst) begin
      m_pend_r = '0; m_srcq = '0; m_mask = 8'h00; m_svc = '0;
      m_ovf = '0; m_ph = 0; m_idx = '0;
    end else begin
      m_sel = ovr_en ? ovr_val : prio(m_pend_r & m_mask);
      for (int k = 0; k < 8; k++) begin
        m_set[k] = src[k] && (!EM[k] || !m_srcq[k]);
        m_clr[k] = (m_ph == 2) && m_svc[k];
      end
      if (ovf_clr) m_ovf = '0;
      m_ovf    = m_ovf | (m_set & m_pend_r & ~m_clr & EM);
      m_pend_r = m_set | (m_pend_r & ~m_clr);
      m_srcq   = src;
      if (mask_wr) m_mask = mask_in;
      if (m_ph == 0) begin
        if (m_sel != 8'h00) begin
          m_svc = m_sel; m_idx = hi(m_sel); m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (ack) m_ph = 2;
      end else begin
        m_ph = 0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("pend", pend, m_pend_r & m_mask);
      cmp("irq", {7'd0, irq}, {7'd0, m_ph == 1});
      cmp("ovf", ovf, m_ovf);
      if (m_ph == 1) cmp("irq_idx", {5'd0, irq_idx}, {5'd0, m_idx});
      if (pin_on) begin
        if (pin_msk[0]) begin
          cmp({pin_name, ".pend"}, pend, pin_pend);
          cmp({pin_name, ".model_pend"}, m_pend_r & m_mask, pin_pend);
        end
        if (pin_msk[1]) begin
          cmp({pin_name, ".irq"}, {7'd0, irq}, {7'd0, pin_irq});
          cmp({pin_name, ".model_irq"}, {7'd0, m_ph == 1}, {7'd0, pin_irq});
        end
        if (pin_msk[2]) begin
          cmp({pin_name, ".idx"}, {5'd0, irq_idx}, {5'd0, pin_idx});
          cmp({pin_name, ".model_idx"}, {5'd0, m_idx}, {5'd0, pin_idx});
        end
        if (pin_msk[3]) begin
          cmp({pin_name, ".ovf"}, ovf, pin_ovf);
          cmp({pin_name, ".model_ovf"}, m_ovf, pin_ovf);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    pin_on = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [3:0] msk, input logic [7:0] p,
                     input logic i, input logic [2:0] x, input logic [7:0] o);
    pin_name = nm; pin_msk = msk; pin_pend = p; pin_irq = i;
    pin_idx = x; pin_ovf = o; pin_on = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    cyc(); chk_on = 1'b1; cyc();
    pin("reset", 4'hF, 8'h00, 1'b0, 3'd0, 8'h00);
    rst = 1'b0; mask_wr = 1'b1; mask_in = 8'hFF; cyc(); mask_wr = 1'b0;

    // Single edge on source 2
    src = 8'h04; cyc(); pin("t1_pend", 4'h3, 8'h04, 1'b0, 3'd0, 8'h00);
    src = 8'h00; cyc(); pin("t1_irq", 4'h7, 8'h04, 1'b1, 3'd2, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; pin("t1_retire", 4'h2, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc(); pin("t1_clr", 4'h3, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc(); pin("t1_gap", 4'h2, 8'h00, 1'b0, 3'd0, 8'h00);

    // Simultaneous sources 1 and 6
    src = 8'h42; cyc(); src = 8'h00; cyc(); pin("t2_first", 4'h6, 8'h00, 1'b1, 3'd6, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); pin("t2_between", 4'h3, 8'h02, 1'b0, 3'd0, 8'h00);
    cyc(); pin("t2_second", 4'h6, 8'h00, 1'b1, 3'd1, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); cyc();

    // Higher source arriving mid-service does not preempt
    src = 8'h08; cyc(); src = 8'h00; cyc();
    src = 8'h80; cyc(); src = 8'h00; cyc(); pin("t3_frozen", 4'h7, 8'h88, 1'b1, 3'd3, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); cyc(); pin("t3_next", 4'h6, 8'h00, 1'b1, 3'd7, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); cyc();

    // Masked source latches and appears on unmask
    mask_wr = 1'b1; mask_in = 8'h00; cyc(); mask_wr = 1'b0;
    src = 8'h10; cyc(); src = 8'h00; cyc(); pin("t4_masked", 4'h3, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc(); mask_wr = 1'b1; mask_in = 8'h10; cyc(); mask_wr = 1'b0;
    pin("t4_unmask", 4'h3, 8'h10, 1'b0, 3'd0, 8'h00);
    cyc(); pin("t4_irq", 4'h6, 8'h00, 1'b1, 3'd4, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc();
    mask_wr = 1'b1; mask_in = 8'hFF; cyc(); mask_wr = 1'b0;

    // Overflow set/clear, clear vs set collision, edge during retire
    src = 8'h20; cyc(); src = 8'h00; cyc();
    src = 8'h20; cyc(); src = 8'h00; pin("t5_ovf", 4'hA, 8'h00, 1'b1, 3'd0, 8'h20);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0; pin("t5_ovfclr", 4'h8, 8'h00, 1'b0, 3'd0, 8'h00);
    src = 8'h20; ovf_clr = 1'b1; cyc(); pin("t5_setwins", 4'h8, 8'h00, 1'b0, 3'd0, 8'h20);
    src = 8'h00; cyc(); ovf_clr = 1'b0; pin("t5_ovfclr2", 4'h8, 8'h00, 1'b0, 3'd0, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; src = 8'h20; cyc(); src = 8'h00;
    pin("t5_retire_edge", 4'hB, 8'h20, 1'b0, 3'd0, 8'h00);
    cyc(); pin("t5_reserve", 4'h6, 8'h00, 1'b1, 3'd5, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); cyc();

    // Level-mode source 7 held high re-pends after retire
    src = 8'h80; cyc(); cyc(); pin("lvl_serve", 4'h6, 8'h00, 1'b1, 3'd7, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); pin("lvl_repend", 4'hB, 8'h80, 1'b0, 3'd0, 8'h00);
    cyc(); pin("lvl_again", 4'hE, 8'h00, 1'b1, 3'd7, 8'h00);
    src = 8'h00; ack = 1'b1; cyc(); ack = 1'b0; cyc(); cyc();

    // Malformed sel: latched unchanged, highest bit encoded, both bits retired
    src = 8'h04; cyc(); src = 8'h00; ovr_en = 1'b1; ovr_val = 8'h24; cyc(); ovr_en = 1'b0;
    pin("bad_sel", 4'h6, 8'h00, 1'b1, 3'd5, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; cyc(); pin("bad_sel_clr", 4'h3, 8'h00, 1'b0, 3'd0, 8'h00);

    // Reset mid-service
    src = 8'h01; cyc(); src = 8'h00; cyc();
    src = 8'h01; cyc(); src = 8'h00; pin("rst_pre", 4'hE, 8'h00, 1'b1, 3'd0, 8'h01);
    rst = 1'b1; cyc(); rst = 1'b0; pin("rst_mid", 4'hF, 8'h00, 1'b0, 3'd0, 8'h00);
    ack = 1'b1; cyc(); ack = 1'b0; pin("rst_ack", 4'h2, 8'h00, 1'b0, 3'd0, 8'h00);
    src = 8'h01; cyc(); src = 8'h00; cyc(); pin("rst_mask", 4'h3, 8'h00, 1'b0, 3'd0, 8'h00);
    cyc(); pin("rst_idle", 4'h2, 8'h00, 1'b0, 3'd0, 8'h00);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
